// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment scanner: per-digit dwell slots with leading blank gap, per-digit enable, 16-level PWM.
// Latency: outputs registered one cycle after counter state; free-running scan, no backpressure.
module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 8,
    parameter int SEG_W          = 8,
    parameter int PRESCALE       = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic [3:0]                  brightness,
    output logic [SEG_W-1:0]            seg,
    output logic [NUM_DIGITS-1:0]       seg_sel,
    output logic                        frame_start
);

    if (NUM_DIGITS < 2 || PRESCALE < 2 || PRESCALE <= BLANK_CYCLES) begin : g_param_err
        $error("seven_seg_scanner: need NUM_DIGITS>=2 and PRESCALE>BLANK_CYCLES, PRESCALE>=2");
    end

    localparam int DW = $clog2(NUM_DIGITS);
    localparam int SW = $clog2(PRESCALE);

    localparam logic [SEG_W-1:0]      SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [NUM_DIGITS-1:0] SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [DW-1:0]         LAST_DIG = DW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0]         LAST_SLT = SW'(PRESCALE - 1);
    localparam logic [SW-1:0]         ON_SLT   = SW'(BLANK_CYCLES);

    logic [DW-1:0]         digit_idx_q, digit_idx_d;
    logic [SW-1:0]         slot_cnt_q, slot_cnt_d;
    logic [3:0]            pwm_cnt_q, pwm_cnt_d;
    logic [SEG_W-1:0]      data_q, data_d;
    logic                  en_q, en_d;
    logic [3:0]            bright_q, bright_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  frame_q, frame_d;

    logic                  on_start, on_phase, lit;
    logic [3:0]            pwm_eff;
    logic [NUM_DIGITS-1:0] onehot;

    always_comb begin
        on_start = (slot_cnt_q == ON_SLT);
        on_phase = (slot_cnt_q >= ON_SLT);

        // The capture cycle itself already displays the freshly sampled values.
        data_d   = on_start ? seg_data[int'(digit_idx_q)*SEG_W +: SEG_W] : data_q;
        en_d     = on_start ? digit_en[digit_idx_q] : en_q;
        bright_d = on_start ? brightness : bright_q;
        pwm_eff  = on_start ? 4'd0 : pwm_cnt_q;
        pwm_cnt_d = on_phase ? pwm_eff + 4'd1 : pwm_cnt_q;

        lit    = on_phase && en_d && (pwm_eff <= bright_d);
        onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx_q;
        seg_d  = lit ? (data_d ^ SEG_OFF) : SEG_OFF;
        sel_d  = lit ? (onehot ^ SEL_OFF) : SEL_OFF;
        frame_d = (digit_idx_q == '0) && (slot_cnt_q == '0);

        slot_cnt_d  = slot_cnt_q + SW'(1);
        digit_idx_d = digit_idx_q;
        if (slot_cnt_q == LAST_SLT) begin
            slot_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == LAST_DIG) ? '0 : digit_idx_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx_q <= '0;
            slot_cnt_q  <= '0;
            pwm_cnt_q   <= '0;
            data_q      <= '0;
            en_q        <= 1'b0;
            bright_q    <= '0;
            seg_q       <= SEG_OFF;
            sel_q       <= SEL_OFF;
            frame_q     <= 1'b0;
        end else begin
            digit_idx_q <= digit_idx_d;
            slot_cnt_q  <= slot_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            data_q      <= data_d;
            en_q        <= en_d;
            bright_q    <= bright_d;
            seg_q       <= seg_d;
            sel_q       <= sel_d;
            frame_q     <= frame_d;
        end
    end

    assign seg         = seg_q;
    assign seg_sel     = sel_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: three instances (short slots, long slots with PWM, inverted polarity).
module tb_seven_seg_scanner;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] sel;
        logic       fs;
    } out_t;

    logic clk;
    bit   clk_run;
    logic rst_n;

    logic [31:0] a_data, b_data, c_data;
    logic [3:0]  a_en, b_en, c_en;
    logic [3:0]  a_br, b_br, c_br;
    logic [7:0]  a_seg, b_seg, c_seg;
    logic [3:0]  a_sel, b_sel, c_sel;
    logic        a_fs, b_fs, c_fs;

    int checks = 0;
    int passed = 0;
    int n;

    logic [7:0] a_cd, b_cd, c_cd;
    logic       a_ce, b_ce, c_ce;
    logic [3:0] a_cb, b_cb, c_cb;

    seven_seg_scanner #(.NUM_DIGITS(4), .SEG_W(8), .PRESCALE(8), .BLANK_CYCLES(2),
                        .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(1)) u_a (
        .clk(clk), .rst_n(rst_n), .seg_data(a_data), .digit_en(a_en), .brightness(a_br),
        .seg(a_seg), .seg_sel(a_sel), .frame_start(a_fs));

    seven_seg_scanner #(.NUM_DIGITS(4), .SEG_W(8), .PRESCALE(40), .BLANK_CYCLES(8),
                        .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst_n(rst_n), .seg_data(b_data), .digit_en(b_en), .brightness(b_br),
        .seg(b_seg), .seg_sel(b_sel), .frame_start(b_fs));

    seven_seg_scanner #(.NUM_DIGITS(4), .SEG_W(8), .PRESCALE(8), .BLANK_CYCLES(2),
                        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(0)) u_c (
        .clk(clk), .rst_n(rst_n), .seg_data(c_data), .digit_en(c_en), .brightness(c_br),
        .seg(c_seg), .seg_sel(c_sel), .frame_start(c_fs));

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Reference: output cycle n shows digit ((n-1)/P)%4 at slot (n-1)%P; ON phase lights the first
    // bright+1 cycles of every 16 using the values captured at the first ON cycle.
    function automatic out_t model(input int cyc, input int p, input int b, input logic [7:0] d,
                                   input logic e, input logic [3:0] br, input bit seg_low, input bit sel_low);
        out_t o;
        int   slot;
        int   dig;
        bit   on;
        slot = (cyc - 1) % p;
        dig  = ((cyc - 1) / p) % 4;
        on   = (slot >= b) && (e == 1'b1) && (((slot - b) % 16) <= int'(br));
        o.seg = on ? d : 8'h00;
        o.sel = on ? 4'(1 << dig) : 4'h0;
        if (seg_low) o.seg = ~o.seg;
        if (sel_low) o.sel = ~o.sel;
        o.fs = (slot == 0) && (dig == 0);
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        if ((n - 1) % 8 == 2) begin
            a_cd = a_data[((n - 1) / 8 % 4) * 8 +: 8];
            a_ce = a_en[(n - 1) / 8 % 4];
            a_cb = a_br;
            c_cd = c_data[((n - 1) / 8 % 4) * 8 +: 8];
            c_ce = c_en[(n - 1) / 8 % 4];
            c_cb = c_br;
        end
        if ((n - 1) % 40 == 8) begin
            b_cd = b_data[((n - 1) / 40 % 4) * 8 +: 8];
            b_ce = b_en[(n - 1) / 40 % 4];
            b_cb = b_br;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #20;
        checks++;
        if ({a_seg, a_sel, a_fs} !== {8'h00, 4'hF, 1'b0})
            $display("FAIL reset_noclk_a: got %h/%h/%b want 00/f/0", a_seg, a_sel, a_fs);
        else passed++;
        checks++;
        if ({c_seg, c_sel, c_fs} !== {8'hFF, 4'h0, 1'b0})
            $display("FAIL reset_noclk_c: got %h/%h/%b want ff/0/0", c_seg, c_sel, c_fs);
        else passed++;
        clk_run = 1'b1;
        a_data = 32'h44332211; a_en = 4'hF; a_br = 4'hF;
        do_reset();
        repeat (5) tick();
        checks++;
        if ({a_seg, a_sel} !== {8'h11, 4'hE})
            $display("FAIL reset_prelit: got %h/%h want 11/e", a_seg, a_sel);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_seg, a_sel, a_fs} !== {8'h00, 4'hF, 1'b0})
            $display("FAIL reset_midslot: got %h/%h/%b want 00/f/0", a_seg, a_sel, a_fs);
        else passed++;
    endtask

    task automatic test_scan();
        out_t e;
        a_data = 32'h44332211; a_en = 4'hF; a_br = 4'hF;
        do_reset();
        repeat (70) begin
            tick();
            e = model(n, 8, 2, a_cd, a_ce, a_cb, 1'b0, 1'b1);
            checks++;
            if ({a_seg, a_sel, a_fs} !== e)
                $display("FAIL scan cycle %0d: got %h/%h/%b want %h/%h/%b", n, a_seg, a_sel, a_fs, e.seg, e.sel, e.fs);
            else passed++;
            if (n == 3 || n == 11 || n == 33) begin
                checks++;
                if ((n == 3 && {a_seg, a_sel} !== {8'h11, 4'hE}) || (n == 11 && {a_seg, a_sel} !== {8'h22, 4'hD}) ||
                    (n == 33 && a_fs !== 1'b1))
                    $display("FAIL scan_fixed cycle %0d: got %h/%h/%b", n, a_seg, a_sel, a_fs);
                else passed++;
            end
        end
    endtask

    task automatic test_enable();
        out_t e;
        int   lit_cnt;
        a_data = $urandom; a_en = 4'b1010; a_br = 4'hF;
        lit_cnt = 0;
        do_reset();
        repeat (70) begin
            tick();
            if (n <= 32 && a_sel != 4'hF) lit_cnt++;
            e = model(n, 8, 2, a_cd, a_ce, a_cb, 1'b0, 1'b1);
            checks++;
            if ({a_seg, a_sel, a_fs} !== e)
                $display("FAIL enable cycle %0d: got %h/%h/%b want %h/%h/%b", n, a_seg, a_sel, a_fs, e.seg, e.sel, e.fs);
            else passed++;
        end
        checks++;
        if (lit_cnt != 12) $display("FAIL enable_lit_count: got %0d want 12", lit_cnt);
        else passed++;
    endtask

    task automatic test_brightness();
        out_t e;
        int   lit_cnt;
        for (int k = 0; k < 2; k++) begin
            b_data = $urandom; b_en = 4'hF; b_br = (k == 0) ? 4'd3 : 4'd0;
            lit_cnt = 0;
            do_reset();
            repeat (160) begin
                tick();
                if (n <= 40 && b_sel != 4'hF) lit_cnt++;
                e = model(n, 40, 8, b_cd, b_ce, b_cb, 1'b0, 1'b1);
                checks++;
                if ({b_seg, b_sel, b_fs} !== e)
                    $display("FAIL bright%0d cycle %0d: got %h/%h/%b want %h/%h/%b", k, n, b_seg, b_sel, b_fs, e.seg, e.sel, e.fs);
                else passed++;
            end
            checks++;
            if (lit_cnt != ((k == 0) ? 8 : 2))
                $display("FAIL bright%0d_lit_count: got %0d want %0d", k, lit_cnt, (k == 0) ? 8 : 2);
            else passed++;
        end
    endtask

    task automatic test_midslot_change();
        out_t e;
        a_data = 32'h44332211; a_en = 4'hF; a_br = 4'hF;
        do_reset();
        repeat (50) begin
            tick();
            e = model(n, 8, 2, a_cd, a_ce, a_cb, 1'b0, 1'b1);
            checks++;
            if ({a_seg, a_sel, a_fs} !== e)
                $display("FAIL midslot cycle %0d: got %h/%h/%b want %h/%h/%b", n, a_seg, a_sel, a_fs, e.seg, e.sel, e.fs);
            else passed++;
            if ((n >= 13 && n <= 16) || n == 43) begin
                checks++;
                if (a_seg !== ((n == 43) ? 8'h5A : 8'h22))
                    $display("FAIL midslot_hold cycle %0d: got %h want %h", n, a_seg, (n == 43) ? 8'h5A : 8'h22);
                else passed++;
            end
            if (n == 12) a_data[15:8] = 8'h5A;
        end
    endtask

    task automatic test_polarity();
        out_t e;
        c_data = {$urandom_range(0, 16'hFFFF), 16'h0011}; c_data[15:8] = 8'($urandom);
        c_en = 4'hF; c_br = 4'hF;
        do_reset();
        repeat (40) begin
            tick();
            e = model(n, 8, 2, c_cd, c_ce, c_cb, 1'b1, 1'b0);
            checks++;
            if ({c_seg, c_sel, c_fs} !== e)
                $display("FAIL polarity cycle %0d: got %h/%h/%b want %h/%h/%b", n, c_seg, c_sel, c_fs, e.seg, e.sel, e.fs);
            else passed++;
            if (n == 1 || n == 3) begin
                checks++;
                if ((n == 1 && {c_seg, c_sel} !== {8'hFF, 4'h0}) || (n == 3 && {c_seg, c_sel} !== {8'hEE, 4'h1}))
                    $display("FAIL polarity_fixed cycle %0d: got %h/%h", n, c_seg, c_sel);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        out_t e;
        a_data = $urandom; a_en = 4'($urandom); a_br = 4'($urandom);
        b_data = $urandom; b_en = 4'($urandom); b_br = 4'($urandom);
        c_data = $urandom; c_en = 4'($urandom); c_br = 4'($urandom);
        do_reset();
        repeat (320) begin
            tick();
            e = model(n, 8, 2, a_cd, a_ce, a_cb, 1'b0, 1'b1);
            checks++;
            if ({a_seg, a_sel, a_fs} !== e)
                $display("FAIL random_a cycle %0d: got %h/%h/%b want %h/%h/%b", n, a_seg, a_sel, a_fs, e.seg, e.sel, e.fs);
            else passed++;
            e = model(n, 40, 8, b_cd, b_ce, b_cb, 1'b0, 1'b1);
            checks++;
            if ({b_seg, b_sel, b_fs} !== e)
                $display("FAIL random_b cycle %0d: got %h/%h/%b want %h/%h/%b", n, b_seg, b_sel, b_fs, e.seg, e.sel, e.fs);
            else passed++;
            e = model(n, 8, 2, c_cd, c_ce, c_cb, 1'b1, 1'b0);
            checks++;
            if ({c_seg, c_sel, c_fs} !== e)
                $display("FAIL random_c cycle %0d: got %h/%h/%b want %h/%h/%b", n, c_seg, c_sel, c_fs, e.seg, e.sel, e.fs);
            else passed++;
            a_data = $urandom; a_en = 4'($urandom); a_br = 4'($urandom);
            b_data = $urandom; b_en = 4'($urandom); b_br = 4'($urandom);
            c_data = $urandom; c_en = 4'($urandom); c_br = 4'($urandom);
        end
    endtask

    initial begin
        clk_run = 1'b0;
        n = 0;
        a_data = '0; b_data = '0; c_data = '0;
        a_en = '0; b_en = '0; c_en = '0;
        a_br = '0; b_br = '0; c_br = '0;
        a_cd = '0; b_cd = '0; c_cd = '0;
        a_ce = 1'b0; b_ce = 1'b0; c_ce = 1'b0;
        a_cb = '0; b_cb = '0; c_cb = '0;
        test_reset();
        test_scan();
        test_enable();
        test_brightness();
        test_midslot_change();
        test_polarity();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
